mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives PC, IR, register-file, ALU-control and memory enables each cycle.
- Stalls on a shared-memory ready handshake.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- HALT_OP, 6'b111111, opcode that stops the sequencer

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  leave IDLE and begin fetching
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (valid in BRANCH)
- mem_ready  in  1  shared memory completes access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition true
- branch_ne  out  1  condition is ~zero (bne) instead of zero (beq)
- iord  out  1  memory address mux: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  2  00=rt, 01=rd, 10=r31
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  3  000 add, 001 sub, 010 R-funct, 011 lui, 100 or
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs (jr)
- busy  out  1  state not IDLE/HALT
- halted  out  1  in HALT
- illegal  out  1  sticky illegal-opcode flag
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, instr_count=0, illegal=0. All outputs 0 in IDLE.
- Outputs are decoded from the state register only; they are glitch-free relative to posedge.
- IDLE -> FETCH when start=1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write assert only while mem_ready=1.
  - mem_ready=0: stay in FETCH with mem_read held.
  - mem_ready=1: -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precompute). Next state by opcode:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 with funct=001000 (jr) -> JR
  - 000000 otherwise -> REXEC
  - 000100 (beq) / 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 000011 (jal) -> JAL
  - 001000 (addi) / 001101 (ori) / 001111 (lui) -> IEXEC
  - HALT_OP -> HALT
  - any other opcode -> illegal path (see Optional Feature)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Next: MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01. -> FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then -> FETCH.
- REXEC: alu_src_a=1, alu_src_b=00, alu_op=010. -> RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00. -> FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10. alu_op=000 for addi, 100 for ori, 011 for lui. -> IWB.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101). -> FETCH.
- JUMP: pc_write=1, pc_source=10. -> FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. -> FETCH. The PC value written to r31 is the already-incremented PC.
- JR: pc_write=1, pc_source=11. -> FETCH.
- HALT: all enables 0, halted=1. Only reset exits; start is ignored.
- instr_count increments by 1 on every transition into FETCH from a non-IDLE state. It wraps modulo 2^CNT_W and does not count the HALT instruction.
- Cycle counts, with mem_ready tied to 1:
  - 3 cycles: branch, j, jal, jr
  - 4 cycles: R-type, immediate ops, sw
  - 5 cycles: lw
  - Each mem_ready=0 cycle adds one cycle.
- mem_read and mem_write are never both 1 in the same cycle.
- Reset asserted mid-instruction, including during a held memory access, returns to IDLE immediately with all outputs 0.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE sets illegal=1 (sticky until reset) and goes to HALT.
- Undefined: an unrecognised opcode is a 3-cycle NOP: DECODE -> FETCH, no enables, still counted as retired. illegal stays 0.

Test Plan:
- Reset low 2 cycles, release, start=1, mem_ready=1, R-type add (opcode 0, funct 100000): exactly 4 cycles FETCH..RWB; reg_write=1 with reg_dst=01 in cycle 4; instr_count=1.
- lw with mem_ready=0 for 3 cycles in MEMRD: mem_read and iord held 3 extra cycles; total 8 cycles; MEMWB asserts reg_write with mem_to_reg=01.
- beq with zero=1, then bne with zero=1: pc_write_cond=1 in both; branch_ne=0 then 1; each takes 3 cycles.
- jal: in cycle 3, pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. jr (funct 001000): pc_source=11, reg_write=0.
- Opcode 111111: halted=1, busy=0, instr_count unchanged; start pulses ignored. Opcode 010000: with MC_ILLEGAL_TRAP_EN, illegal=1 and halted=1; without it, NOP and instr_count+1.
- Assert reset during a MEMWR stall: outputs 0 asynchronously, state IDLE, instr_count=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle Moore sequencer for the MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// stalls on the shared-memory mem_ready handshake and counts retired
// instructions.
//
// Handshake: a memory access is requested by holding mem_read or mem_write
// high; the access completes in the cycle where mem_ready is also high, and
// the sequencer only advances past FETCH/MEMRD/MEMWR in such a cycle.
//
// Optional build macro MC_ILLEGAL_TRAP_EN: when defined, an unrecognised
// opcode sets the sticky illegal flag and parks the sequencer in HALT; when
// undefined it retires as a 3-cycle NOP (FETCH, DECODE, NOP) with no enables.
//
// dbg_state exposes the raw state register for checkers.
module mc_control_fsm #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [4:0]       dbg_state
);

  // State encoding
  localparam logic [4:0] ST_IDLE   = 5'd0;
  localparam logic [4:0] ST_FETCH  = 5'd1;
  localparam logic [4:0] ST_DECODE = 5'd2;
  localparam logic [4:0] ST_MEMADR = 5'd3;
  localparam logic [4:0] ST_MEMRD  = 5'd4;
  localparam logic [4:0] ST_MEMWB  = 5'd5;
  localparam logic [4:0] ST_MEMWR  = 5'd6;
  localparam logic [4:0] ST_REXEC  = 5'd7;
  localparam logic [4:0] ST_RWB    = 5'd8;
  localparam logic [4:0] ST_IEXEC  = 5'd9;
  localparam logic [4:0] ST_IWB    = 5'd10;
  localparam logic [4:0] ST_BRANCH = 5'd11;
  localparam logic [4:0] ST_JUMP   = 5'd12;
  localparam logic [4:0] ST_JAL    = 5'd13;
  localparam logic [4:0] ST_JR     = 5'd14;
  localparam logic [4:0] ST_HALT   = 5'd15;
  localparam logic [4:0] ST_NOP    = 5'd16;

  // Opcodes / functs
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]       state_q, state_d;
  logic [4:0]       dec_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
`ifdef MC_ILLEGAL_TRAP_EN
  logic             dec_illegal;
`endif

  // The ALU zero flag is consumed by the datapath's PC-write gating, not here.
  logic unused_zero;
  assign unused_zero = zero;

  // Opcode decode: the state DECODE hands off to.
  always_comb begin
    dec_next = ST_HALT;
`ifdef MC_ILLEGAL_TRAP_EN
    dec_illegal = 1'b0;
`endif
    case (opcode)
      OP_LW, OP_SW:           dec_next = ST_MEMADR;
      OP_RTYPE:               dec_next = (funct == FN_JR) ? ST_JR : ST_REXEC;
      OP_BEQ, OP_BNE:         dec_next = ST_BRANCH;
      OP_J:                   dec_next = ST_JUMP;
      OP_JAL:                 dec_next = ST_JAL;
      OP_ADDI, OP_ORI, OP_LUI: dec_next = ST_IEXEC;
      default: begin
        if (opcode == HALT_OP) begin
          dec_next = ST_HALT;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          dec_illegal = 1'b1;
          dec_next    = ST_HALT;
`else
          dec_next    = ST_NOP;
`endif
        end
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_next;
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_REXEC:  state_d = ST_RWB;
      ST_IEXEC:  state_d = ST_IWB;
      ST_MEMWB, ST_RWB, ST_IWB, ST_BRANCH,
      ST_JUMP, ST_JAL, ST_JR, ST_NOP:
                 state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Retire counter and sticky illegal flag
  always_comb begin
    count_d = count_q;
    // Entering FETCH from an instruction's last state retires it; the first
    // fetch after IDLE and the FETCH stall loop do not.
    if ((state_d == ST_FETCH) && (state_q != ST_IDLE) && (state_q != ST_FETCH)) begin
      count_d = count_q + CNT_ONE;
    end
    illegal_d = illegal_q;
`ifdef MC_ILLEGAL_TRAP_EN
    if ((state_q == ST_DECODE) && dec_illegal) begin
      illegal_d = 1'b1;
    end
`endif
  end

  // State, counter and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode; FETCH qualifies IR/PC load with mem_ready so the
  // instruction word is captured only when memory delivers it.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
    halted        = (state_q == ST_HALT);
    illegal       = illegal_q;
    instr_count   = count_q;
    dbg_state     = state_q;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      ST_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      ST_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ORI)      alu_op = 3'b100;
        else if (opcode == OP_LUI) alu_op = 3'b011;
        else                       alu_op = 3'b000;
      end
      ST_IWB: begin
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ST_JAL: begin
        // r31 receives the PC already incremented during FETCH.
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      ST_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: each instruction is expanded into its expected per-cycle
// control words (from the instruction class, fetch stall count and memory
// stall count) and pushed onto a scoreboard queue; one driver/compare loop
// replays the planned mem_ready pattern and compares every cycle.
module tb_mc_control_fsm;
  localparam int CNT_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       busy;
    logic       halted;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic       mr;
    logic       st;
    logic [5:0] op;
    logic [5:0] fn;
  } stim_t;

  // clock / reset / DUT signals
  logic clk = 1'b0;
  logic reset, start, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic reg_write, alu_src_a, busy, halted, illegal;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] instr_count;
  logic [4:0] dbg_state_unused;

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(CNT_W), .HALT_OP(OP_HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .busy(busy), .halted(halted), .illegal(illegal),
    .instr_count(instr_count), .dbg_state(dbg_state_unused)
  );

  ctl_t act;
  assign act = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                alu_op, pc_source, busy, halted, illegal};

  // scoreboard
  logic [$bits(ctl_t)-1:0] exp_q[$];
  logic [CNT_W-1:0]        cnt_q[$];
  stim_t                   stim_q[$];
  logic [CNT_W-1:0]        model_count;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input ctl_t c, input logic mr, input logic st,
                      input logic [5:0] op, input logic [5:0] fn);
    stim_t s;
    s.mr = mr; s.st = st; s.op = op; s.fn = fn;
    exp_q.push_back(c);
    cnt_q.push_back(model_count);
    stim_q.push_back(s);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fstall, input int mstall);
    ctl_t c;
    for (int i = 0; i < fstall; i++) begin
      c = '0; c.busy = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
      push(c, 1'b0, rnd_bit(), op, fn);
    end
    c = '0; c.busy = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    c.ir_write = 1'b1; c.pc_write = 1'b1;
    push(c, 1'b1, rnd_bit(), op, fn);
    c = '0; c.busy = 1'b1; c.alu_src_b = 2'b11;
    push(c, rnd_bit(), rnd_bit(), op, fn);
    if (op == OP_LW || op == OP_SW) begin
      c = '0; c.busy = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      push(c, rnd_bit(), rnd_bit(), op, fn);
      c = '0; c.busy = 1'b1; c.iord = 1'b1;
      if (op == OP_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
      for (int i = 0; i < mstall; i++) push(c, 1'b0, rnd_bit(), op, fn);
      push(c, 1'b1, rnd_bit(), op, fn);
      if (op == OP_LW) begin
        c = '0; c.busy = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 2'b01;
        push(c, rnd_bit(), rnd_bit(), op, fn);
      end
    end else if (op == OP_RTYPE && fn == FN_JR) begin
      c = '0; c.busy = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'b11;
      push(c, rnd_bit(), rnd_bit(), op, fn);
    end else if (op == OP_RTYPE) begin
      c = '0; c.busy = 1'b1; c.alu_src_a = 1'b1; c.alu_op = 3'b010;
      push(c, rnd_bit(), rnd_bit(), op, fn);
      c = '0; c.busy = 1'b1; c.reg_write = 1'b1; c.reg_dst = 2'b01;
      push(c, rnd_bit(), rnd_bit(), op, fn);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      c = '0; c.busy = 1'b1; c.alu_src_a = 1'b1; c.alu_op = 3'b001;
      c.pc_write_cond = 1'b1; c.pc_source = 2'b01; c.branch_ne = (op == OP_BNE);
      push(c, rnd_bit(), rnd_bit(), op, fn);
    end else if (op == OP_J || op == OP_JAL) begin
      c = '0; c.busy = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'b10;
      if (op == OP_JAL) begin
        c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
      end
      push(c, rnd_bit(), rnd_bit(), op, fn);
    end else if (op == OP_ADDI || op == OP_ORI || op == OP_LUI) begin
      c = '0; c.busy = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      c.alu_op = (op == OP_ORI) ? 3'b100 : (op == OP_LUI) ? 3'b011 : 3'b000;
      push(c, rnd_bit(), rnd_bit(), op, fn);
      c = '0; c.busy = 1'b1; c.reg_write = 1'b1;
      push(c, rnd_bit(), rnd_bit(), op, fn);
    end else if (op == OP_HALT) begin
      c = '0; c.halted = 1'b1;
      for (int i = 0; i < 6; i++) push(c, rnd_bit(), i[0], op, fn);
      return;
    end else begin
`ifdef MC_ILLEGAL_TRAP_EN
      c = '0; c.halted = 1'b1; c.illegal = 1'b1;
      for (int i = 0; i < 6; i++) push(c, rnd_bit(), i[0], op, fn);
      return;
`else
      c = '0; c.busy = 1'b1;
      push(c, rnd_bit(), rnd_bit(), op, fn);
`endif
    end
    model_count = model_count + 1;
  endtask

  // Driver + compare: called at posedge+1, consumes up to n planned cycles.
  task automatic run_plan(input int n);
    stim_t s;
    logic [$bits(ctl_t)-1:0] e;
    logic [CNT_W-1:0] c;
    int k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      mem_ready = s.mr; start = s.st; opcode = s.op; funct = s.fn;
      zero = rnd_bit();
      @(negedge clk);
      check("ctl", 32'(act), 32'(e));
      check("instr_count", instr_count, c);
      @(posedge clk); #1;
      k++; cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    exp_q.delete(); cnt_q.delete(); stim_q.delete();
    model_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 32'(act), 32'd0);
    check("reset_count", instr_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // From IDLE (at posedge+1): idle must hold without start, then start fetching.
  task automatic start_run();
    start = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("idle_ctl", 32'(act), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_hold", 32'(act), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  logic [5:0] legal_ops[11];
  logic [5:0] bad_ops[4];

  initial begin
    logic [5:0] op, fn;
    int k;
    legal_ops = '{OP_RTYPE, OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                  OP_J, OP_JAL, OP_ADDI, OP_ORI, OP_LUI};
    bad_ops   = '{6'b010000, 6'b000001, 6'b110000, 6'b011111};

    // Directed sequence
    do_reset();
    start_run();
    plan_instr(OP_RTYPE, FN_ADD, 0, 0);
    check("plan_rtype_len", exp_q.size(), 32'd4);
    run_plan(-1);
    plan_instr(OP_LW, 6'h00, 0, 3);
    check("plan_lw_stall_len", exp_q.size(), 32'd8);
    run_plan(-1);
    plan_instr(OP_BEQ, 6'h00, 0, 0);
    check("plan_beq_len", exp_q.size(), 32'd3);
    plan_instr(OP_BNE, 6'h00, 0, 0);
    plan_instr(OP_JAL, 6'h00, 0, 0);
    plan_instr(OP_RTYPE, FN_JR, 0, 0);
    plan_instr(OP_SW, 6'h00, 0, 0);
    check("plan_branch_jal_jr_sw_len", exp_q.size(), 32'd16);
    run_plan(-1);
    check("model_count_directed", model_count, 32'd7);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 10);
`else
      k = $urandom_range(0, 11);
`endif
      if (k == 11) op = bad_ops[$urandom_range(0, 3)];
      else         op = legal_ops[k];
      fn = 6'($urandom_range(0, 63));
      if (op == OP_RTYPE && $urandom_range(0, 3) == 0) fn = FN_JR;
      else if (op == OP_RTYPE && fn == FN_JR)          fn = FN_ADD;
      plan_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      run_plan(-1);
    end

    // Asynchronous reset during a held MEMWR access
    plan_instr(OP_SW, 6'h00, 0, 6);
    run_plan(5);
    check("memwr_stall_write", {31'd0, mem_write}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_ctl", 32'(act), 32'd0);
    check("async_reset_count", instr_count, 32'd0);
    exp_q.delete(); cnt_q.delete(); stim_q.delete();
    model_count = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // HALT: retired count unchanged, start pulses ignored
    start_run();
    plan_instr(OP_RTYPE, FN_ADD, 1, 0);
    plan_instr(OP_HALT, 6'h00, 0, 0);
    run_plan(-1);
    check("halt_count", instr_count, 32'd1);

    // Unrecognised opcode 010000
    do_reset();
    start_run();
    plan_instr(6'b010000, 6'h00, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    run_plan(-1);
    check("trap_illegal", {31'd0, illegal}, 32'd1);
    check("trap_count", instr_count, 32'd0);
`else
    check("plan_nop_len", exp_q.size(), 32'd3);
    plan_instr(OP_ADDI, 6'h00, 0, 0);
    run_plan(-1);
    check("nop_illegal", {31'd0, illegal}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
